// File: rtl/gc_refresh_scheduler.sv
// gc_refresh_scheduler: per-bank refresh debt tracking and a 2-cycle read/write-back refresh sequencer.
// Optional macro GC_REF_OPPORTUNISTIC_EN: non-urgent refreshes avoid banks the user is accessing this cycle.
module gc_refresh_scheduler #(
    parameter int BANKS    = 8,
    parameter int ROWS     = 128,
    parameter int ROW_BITS = 7,
    parameter int INTERVAL = 38,
    parameter int MAX_PEND = 4,
    parameter int URG_PEND = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                disable_ref,
    input  logic [BANKS-1:0]    user_req_bank,
    output logic [BANKS-1:0]    ref_re,
    output logic [BANKS-1:0]    ref_we,
    output logic [ROW_BITS-1:0] ref_addr,
    output logic [2:0]          ref_bank,
    output logic [BANKS-1:0]    busy_bank,
    output logic                ref_done,
    output logic                err_overflow
);
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int PW = $clog2(MAX_PEND + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t              state;
    logic [TW-1:0]       tick_cnt;
    logic [PW-1:0]       pending [BANKS];
    logic [ROW_BITS-1:0] row_ptr [BANKS];
    logic [BW-1:0]       rr_ptr;
    logic [BW-1:0]       sel;

    logic                tick;
    logic [BANKS-1:0]    urgent;
    logic [BANKS-1:0]    eligible;
    logic [BANKS-1:0]    cand;
    logic [BANKS-1:0]    done_vec;
    logic                found;
    logic [BW-1:0]       pick;
    int unsigned         scan_idx;

    function automatic logic [BANKS-1:0] onehot(input logic [BW-1:0] idx);
        return {{(BANKS-1){1'b0}}, 1'b1} << idx;
    endfunction

`ifndef GC_REF_OPPORTUNISTIC_EN
    logic unused_user_req;
    assign unused_user_req = ^user_req_bank;
`endif

    always_comb begin
        tick     = (tick_cnt == TW'(INTERVAL - 1));
        urgent   = '0;
        eligible = '0;
        for (int b = 0; b < BANKS; b++) begin
            urgent[b]   = (pending[b] >= PW'(URG_PEND));
            eligible[b] = (pending[b] != '0);
        end
`ifdef GC_REF_OPPORTUNISTIC_EN
        eligible = eligible & ~user_req_bank;
`endif
        cand = (|urgent) ? urgent : eligible;

        // Scan downward so the candidate closest above rr_ptr is the last one written.
        found    = 1'b0;
        pick     = '0;
        scan_idx = 0;
        for (int i = BANKS - 1; i >= 0; i--) begin
            scan_idx = (int'(rr_ptr) + i) % BANKS;
            if (cand[BW'(scan_idx)]) begin
                found = 1'b1;
                pick  = BW'(scan_idx);
            end
        end

        done_vec = (state == WRITE) ? onehot(sel) : '0;
    end

    assign ref_done = (state == WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            rr_ptr       <= '0;
            sel          <= '0;
            ref_re       <= '0;
            ref_we       <= '0;
            ref_addr     <= '0;
            ref_bank     <= '0;
            busy_bank    <= '0;
            err_overflow <= 1'b0;
            for (int b = 0; b < BANKS; b++) begin
                pending[b] <= '0;
                row_ptr[b] <= '0;
            end
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

            // A credit and a completion on the same bank cancel out.
            for (int b = 0; b < BANKS; b++) begin
                if (tick && !done_vec[b]) begin
                    if (pending[b] == PW'(MAX_PEND))
                        err_overflow <= 1'b1;
                    else
                        pending[b] <= pending[b] + PW'(1);
                end else if (!tick && done_vec[b]) begin
                    pending[b] <= pending[b] - PW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (!disable_ref && found) begin
                        state     <= READ;
                        sel       <= pick;
                        ref_re    <= onehot(pick);
                        busy_bank <= onehot(pick);
                        ref_addr  <= row_ptr[pick];
                        ref_bank  <= 3'(pick);
                    end
                end
                READ: begin
                    state  <= WRITE;
                    ref_re <= '0;
                    ref_we <= ref_re;
                end
                WRITE: begin
                    state        <= IDLE;
                    ref_we       <= '0;
                    busy_bank    <= '0;
                    ref_addr     <= '0;
                    ref_bank     <= '0;
                    row_ptr[sel] <= (row_ptr[sel] == ROW_BITS'(ROWS - 1)) ? '0
                                                                         : row_ptr[sel] + ROW_BITS'(1);
                    rr_ptr       <= (sel == BW'(BANKS - 1)) ? '0 : sel + BW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gc_refresh_scheduler.sv
// Bench for gc_refresh_scheduler: behavioural credit/round-robin model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gc_refresh_scheduler;
    localparam int BANKS    = 8;
    localparam int ROWS     = 128;
    localparam int ROW_BITS = 7;
    localparam int INTERVAL = 4;
    localparam int MAX_PEND = 4;
    localparam int URG_PEND = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                disable_ref = 1'b0;
    logic [BANKS-1:0]    user_req_bank = '0;
    logic [BANKS-1:0]    ref_re;
    logic [BANKS-1:0]    ref_we;
    logic [ROW_BITS-1:0] ref_addr;
    logic [2:0]          ref_bank;
    logic [BANKS-1:0]    busy_bank;
    logic                ref_done;
    logic                err_overflow;

    gc_refresh_scheduler #(
        .BANKS(BANKS), .ROWS(ROWS), .ROW_BITS(ROW_BITS),
        .INTERVAL(INTERVAL), .MAX_PEND(MAX_PEND), .URG_PEND(URG_PEND)
    ) dut (
        .clk(clk), .rst(rst), .disable_ref(disable_ref), .user_req_bank(user_req_bank),
        .ref_re(ref_re), .ref_we(ref_we), .ref_addr(ref_addr), .ref_bank(ref_bank),
        .busy_bank(busy_bank), .ref_done(ref_done), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: debt per bank, next row per bank, and the refresh in flight (age 1 = read, 2 = write).
    int m_pend [BANKS];
    int m_row  [BANKS];
    int m_rr, m_age, m_bank, m_addr, m_tick;
    bit m_err, m_valid = 1'b0;

    function automatic bit user_allows(input int b);
`ifdef GC_REF_OPPORTUNISTIC_EN
        return !user_req_bank[b];
`else
        return (b >= 0);
`endif
    endfunction

    function automatic int model_pick();
        bit any_urg = 1'b0;
        int b;
        for (int i = 0; i < BANKS; i++) if (m_pend[i] >= URG_PEND) any_urg = 1'b1;
        for (int i = 0; i < BANKS; i++) begin
            b = (m_rr + i) % BANKS;
            if (any_urg) begin
                if (m_pend[b] >= URG_PEND) return b;
            end else if (m_pend[b] > 0 && user_allows(b)) begin
                return b;
            end
        end
        return -1;
    endfunction

    task automatic model_step();
        int done_b, start_b;
        bit tick;
        if (rst) begin
            for (int b = 0; b < BANKS; b++) begin m_pend[b] = 0; m_row[b] = 0; end
            m_rr = 0; m_age = 0; m_bank = 0; m_addr = 0; m_tick = 0; m_err = 1'b0;
            m_valid = 1'b1;
            return;
        end
        done_b  = (m_age == 2) ? m_bank : -1;
        start_b = (m_age == 0 && !disable_ref) ? model_pick() : -1;
        tick    = (m_tick == INTERVAL - 1);
        for (int b = 0; b < BANKS; b++) begin
            if (tick && b != done_b) begin
                if (m_pend[b] == MAX_PEND) m_err = 1'b1;
                else m_pend[b] = m_pend[b] + 1;
            end else if (!tick && b == done_b) begin
                m_pend[b] = m_pend[b] - 1;
            end
        end
        if (done_b >= 0) begin
            m_row[done_b] = (m_row[done_b] + 1) % ROWS;
            m_rr  = (done_b + 1) % BANKS;
            m_age = 0;
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (start_b >= 0) begin
            m_age  = 1;
            m_bank = start_b;
            m_addr = m_row[start_b];
        end
        m_tick = (m_tick + 1) % INTERVAL;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        logic [BANKS-1:0] sel_vec;
        @(negedge clk);
        if (m_valid) begin
            sel_vec = (m_age != 0) ? BANKS'(1) << m_bank : '0;
            check("model_ref_re",    32'(ref_re),    (m_age == 1) ? 32'(sel_vec) : 32'd0);
            check("model_ref_we",    32'(ref_we),    (m_age == 2) ? 32'(sel_vec) : 32'd0);
            check("model_busy_bank", 32'(busy_bank), 32'(sel_vec));
            check("model_ref_addr",  32'(ref_addr),  (m_age != 0) ? 32'(m_addr) : 32'd0);
            check("model_ref_bank",  32'(ref_bank),  (m_age != 0) ? 32'(m_bank) : 32'd0);
            check("model_ref_done",  32'(ref_done),  32'(m_age == 2));
            check("model_err_ovf",   32'(err_overflow), 32'(m_err));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic wait_re(input logic [BANKS-1:0] want, input int limit, input string name);
        int k = 0;
        while (!((want == '0) ? (ref_re != '0) : (ref_re == want)) && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (k >= limit) begin
            checks++;
            errors++;
            $display("FAIL %s: ref_re never reached %0h within %0d cycles (last %0h)", name, want, limit, ref_re);
        end
    endtask

    function automatic logic [BANKS-1:0] rand_user();
        int r = $urandom_range(0, BANKS);
        return (r == BANKS) ? '0 : BANKS'(1) << r;
    endfunction

    initial begin
        int cnt3;
        int k;

        // Directed: first tick at the 4th edge after reset, then round-robin.
        user_req_bank = '0;
        disable_ref   = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(5);
        check("first_read_re",   32'(ref_re), 32'h01);
        check("first_read_addr", 32'(ref_addr), 32'd0);
        check("first_read_busy", 32'(busy_bank), 32'h01);
        cycles(1);
        check("first_write_we",   32'(ref_we), 32'h01);
        check("first_write_done", 32'(ref_done), 32'd1);
        cycles(2);
        check("second_read_re", 32'(ref_re), 32'h02);
        cycles(3);
        check("third_read_re", 32'(ref_re), 32'h04);

        // All banks requested by the user.
        do_reset();
        user_req_bank = 8'hFF;
`ifdef GC_REF_OPPORTUNISTIC_EN
        cycles(12);
        check("allreq_wait_urgent", 32'(ref_re), 32'h00);
        cycles(1);
`else
        cycles(5);
`endif
        check("allreq_bank0_re", 32'(ref_re), 32'h01);
        user_req_bank = '0;

        // Reset in the middle of a READ aborts it.
        do_reset();
        wait_re(8'h02, 40, "wait_bank1_read");
        rst = 1'b1;
        cycles(1);
        check("rst_abort_re",   32'(ref_re), 32'h00);
        check("rst_abort_busy", 32'(busy_bank), 32'h00);
        check("rst_abort_done", 32'(ref_done), 32'd0);
        rst = 1'b0;
        cycles(5);
        check("post_rst_re",   32'(ref_re), 32'h01);
        check("post_rst_addr", 32'(ref_addr), 32'd0);

        // disable_ref: credits accrue until the 5th tick overflows.
        rst = 1'b1;
        disable_ref = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(19);
        check("dis_no_err_yet", 32'(err_overflow), 32'd0);
        check("dis_no_read",    32'(ref_re), 32'h00);
        cycles(1);
        check("dis_err_set", 32'(err_overflow), 32'd1);
        disable_ref = 1'b0;
        wait_re('0, 10, "wait_resume");
        check("resume_err_sticky", 32'(err_overflow), 32'd1);

        // Row pointer wrap on bank 3.
        do_reset();
        cnt3 = 0;
        k = 0;
        while (cnt3 < 129 && k < 8000) begin
            user_req_bank = rand_user();
            @(negedge clk);
            k++;
            if (ref_re == 8'h08) begin
                cnt3++;
                if (cnt3 == 1)   check("bank3_row_first", 32'(ref_addr), 32'd0);
                if (cnt3 == 128) check("bank3_row_last",  32'(ref_addr), 32'd127);
                if (cnt3 == 129) check("bank3_row_wrap",  32'(ref_addr), 32'd0);
            end
        end
        if (cnt3 < 129) begin
            checks++;
            errors++;
            $display("FAIL bank3_wrap_timeout: only %0d refreshes of bank3, needed 129", cnt3);
        end

        // Random traffic with occasional disable and reset.
        for (int i = 0; i < 2500; i++) begin
            user_req_bank = rand_user();
            disable_ref   = ($urandom_range(0, 9) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        disable_ref = 1'b0;
        cycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
